// File: rtl/attn_core_sequencer_if.sv
// Handshake/bus bundle between the attention-core sequencer and the host stream / core.
// The sequencer uses the slave modport; the host/core side uses master.
interface attn_core_sequencer_if;
  logic        start;
  logic [4:0]  n_q;
  logic [4:0]  n_k;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_valid;
  logic [16:0] inst;
  logic        sum_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;

  modport master (
    output start, n_q, n_k, in_valid, fifo_valid,
    input  in_ready, inst, sum_valid, busy, done, cfg_err
  );

  modport slave (
    input  start, n_q, n_k, in_valid, fifo_valid,
    output in_ready, inst, sum_valid, busy, done, cfg_err
  );
endinterface

// File: rtl/attn_core_sequencer.sv
// Job sequencer for the Q/K attention core: streams Q/K rows in, loads K, executes Q with
// overlapped ofifo->psum drain, then reads psum back. ATTN_SEQ_PERF_EN adds perf counters.
module attn_core_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int MAC_DLY = 1,
  parameter int SUM_LAT = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  attn_core_sequencer_if.slave bus
`ifdef ATTN_SEQ_PERF_EN
  ,
  output logic [31:0] perf_cycles_o,
  output logic [31:0] perf_stall_o
`endif
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_W);

  typedef enum logic [2:0] {IDLE, QWR, KWR, KLOAD, EXEC, DRAIN, PRD, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       nq_q, nq_d, nk_q, nk_d, cnt_q, cnt_d, dcnt_q, dcnt_d;
  logic                rdo_q, rdo_d;
  logic [ADDR_W-1:0]   qka_q, qka_d, pa_q, pa_d;
  logic [5:0]          strb_q, strb_d;
  logic                in_ready_q, busy_q, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [MAC_DLY-1:0]  ld_q, ex_q;
  logic [SUM_LAT-1:0]  sv_q;
  logic [CW-1:0]       nq_cl, nk_cl;
  logic                accept, ex_pend, sv_early, draining;

  assign bus.inst      = {rdo_q, qka_q, pa_q, ex_q[MAC_DLY-1], ld_q[MAC_DLY-1], strb_q};
  assign bus.in_ready  = in_ready_q;
  assign bus.sum_valid = sv_q[SUM_LAT-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = cfg_err_q;

  assign nq_cl    = (CW'(bus.n_q) > DEPTH) ? DEPTH : CW'(bus.n_q);
  assign nk_cl    = (CW'(bus.n_k) > DEPTH) ? DEPTH : CW'(bus.n_k);
  assign accept   = in_ready_q & bus.in_valid;
  assign ex_pend  = strb_q[5] | (|ex_q);
  assign draining = (state_q == EXEC || state_q == DRAIN) && bus.fifo_valid && (dcnt_q != nq_q);

  always_comb begin
    sv_early = strb_q[1];
    for (int i = 0; i < SUM_LAT-1; i++) sv_early = sv_early | sv_q[i];
  end

  always_comb begin
    state_d   = state_q;
    nq_d      = nq_q;
    nk_d      = nk_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    rdo_d     = 1'b0;
    qka_d     = '0;
    pa_d      = '0;
    strb_d    = '0;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.n_q == '0 || bus.n_k == '0) cfg_err_d = 1'b1;
        else begin
          state_d = QWR;
          nq_d    = nq_cl;
          nk_d    = nk_cl;
          cnt_d   = '0;
          dcnt_d  = '0;
        end
      end
      QWR: if (accept) begin
        strb_d[4] = 1'b1;
        qka_d     = cnt_q[ADDR_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d == nq_q) begin state_d = KWR; cnt_d = '0; end
      end
      KWR: if (accept) begin
        strb_d[2] = 1'b1;
        qka_d     = cnt_q[ADDR_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d == nk_q) begin state_d = KLOAD; cnt_d = '0; end
      end
      KLOAD: begin
        strb_d[3] = 1'b1;
        qka_d     = cnt_q[ADDR_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d == nk_q) begin state_d = EXEC; cnt_d = '0; end
      end
      EXEC: begin
        if (cnt_q != nq_q) begin
          strb_d[5] = 1'b1;
          qka_d     = cnt_q[ADDR_W-1:0];
          cnt_d     = cnt_q + 1'b1;
        end else if (!ex_pend) state_d = DRAIN;
      end
      DRAIN: if (dcnt_q == nq_q) begin state_d = PRD; cnt_d = '0; end
      PRD: begin
        strb_d[1] = 1'b1;
        pa_d      = cnt_q[ADDR_W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d == nq_q) begin state_d = FLUSH; cnt_d = '0; end
      end
      FLUSH: if (!sv_early && sv_q[SUM_LAT-1]) begin state_d = IDLE; done_d = 1'b1; end
      default: state_d = IDLE;
    endcase
    // ofifo->pmem drain runs alongside execute so the 8-deep ofifo never fills
    if (draining) begin
      rdo_d     = 1'b1;
      strb_d[0] = 1'b1;
      pa_d      = dcnt_q[ADDR_W-1:0];
      dcnt_d    = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      nq_q       <= '0;
      nk_q       <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      rdo_q      <= 1'b0;
      qka_q      <= '0;
      pa_q       <= '0;
      strb_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      ld_q       <= '0;
      ex_q       <= '0;
      sv_q       <= '0;
    end else begin
      state_q    <= state_d;
      nq_q       <= nq_d;
      nk_q       <= nk_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      rdo_q      <= rdo_d;
      qka_q      <= qka_d;
      pa_q       <= pa_d;
      strb_q     <= strb_d;
      in_ready_q <= (state_d == QWR) || (state_d == KWR);
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      // MAC bits trail their SRAM read strobes; sum_valid trails pmem_rd
      ld_q[0]    <= strb_q[3];
      ex_q[0]    <= strb_q[5];
      sv_q[0]    <= strb_q[1];
      for (int i = 1; i < MAC_DLY; i++) begin
        ld_q[i] <= ld_q[i-1];
        ex_q[i] <= ex_q[i-1];
      end
      for (int i = 1; i < SUM_LAT; i++) sv_q[i] <= sv_q[i-1];
    end
  end

`ifdef ATTN_SEQ_PERF_EN
  logic [31:0] pcyc_q, pstall_q;
  logic        stall;

  assign stall = ((state_q == QWR || state_q == KWR) && !bus.in_valid) ||
                 (state_q == DRAIN && !bus.fifo_valid);
  assign perf_cycles_o = pcyc_q;
  assign perf_stall_o  = pstall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || (state_q == IDLE && state_d == QWR)) begin
      pcyc_q   <= '0;
      pstall_q <= '0;
    end else begin
      if (state_q != IDLE && pcyc_q != '1) pcyc_q <= pcyc_q + 1'b1;
      if (stall && pstall_q != '1)         pstall_q <= pstall_q + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_attn_core_sequencer.sv
// Directed bench for attn_core_sequencer with a small core model (q/k/p memories, ofifo, sum path).
module tb_attn_core_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_in;
  attn_core_sequencer_if bus();
`ifdef ATTN_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  always #5 clk = ~clk;

  attn_core_sequencer dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
`ifdef ATTN_SEQ_PERF_EN
    ,
    .perf_cycles_o (perf_cycles),
    .perf_stall_o  (perf_stall)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // stimulus rows and golden K sum
  int qd[16], kd[16], job_ksum;

  // core model state
  int qmem[16], kmem[16], pmem[16];
  int dq[$], lq[$], eq[$], fq[$], sq[$];
  int ksum_m, viol, addr_err, fifo_max;
  int c_qwr, c_kwr, c_krd, c_qrd, c_ld, c_ex, c_pwr, c_prd, c_sv, c_done, c_cfg;
  int busy_cyc, idle_cyc;
  logic [16:0] mi;
  int qa, pa;

  function automatic void clr_model();
    dq.delete(); lq.delete(); eq.delete(); fq.delete(); sq.delete();
    ksum_m = 0; viol = 0; addr_err = 0; fifo_max = 0;
    c_qwr = 0; c_kwr = 0; c_krd = 0; c_qrd = 0; c_ld = 0; c_ex = 0;
    c_pwr = 0; c_prd = 0; c_sv = 0; c_done = 0; c_cfg = 0;
    busy_cyc = 0; idle_cyc = 0;
  endfunction

  // The model consumes an ofifo read during the cycle inst shows it, so fifo_valid
  // seen at the next edge is already net of that read.
  always @(negedge clk) begin
    mi = bus.inst;
    qa = int'(mi[15:12]);
    pa = int'(mi[11:8]);
    if (reset) begin
      clr_model();
      bus.fifo_valid = 1'b0;
    end else begin
      if (bus.start && !bus.busy) clr_model();
      if (bus.in_ready && bus.in_valid) dq.push_back(int'(mem_in));
      if (bus.busy) busy_cyc++;
      if (bus.in_ready && !bus.in_valid) idle_cyc++;
      if ((mi[5] & mi[4]) | (mi[3] & mi[2]) | (mi[1] & mi[0]) | ((mi[5] | mi[4]) & (mi[3] | mi[2])) |
          (mi[16] ^ mi[0])) viol++;
      if (mi[4]) begin
        if (qa != c_qwr) addr_err++;
        if (dq.size() > 0) qmem[qa] = dq.pop_front(); else viol++;
        c_qwr++;
      end
      if (mi[2]) begin
        if (qa != c_kwr) addr_err++;
        if (dq.size() > 0) kmem[qa] = dq.pop_front(); else viol++;
        c_kwr++;
      end
      if (mi[6]) begin
        if (lq.size() > 0) ksum_m += lq.pop_front(); else viol++;
        c_ld++;
      end
      if (mi[7]) begin
        if (eq.size() > 0) fq.push_back(eq.pop_front() * ksum_m); else viol++;
        c_ex++;
      end
      if (mi[3]) begin
        if (qa != c_krd) addr_err++;
        lq.push_back(kmem[qa]);
        c_krd++;
      end
      if (mi[5]) begin
        if (qa != c_qrd) addr_err++;
        eq.push_back(qmem[qa]);
        c_qrd++;
      end
      if (mi[16]) begin
        if (pa != c_pwr) addr_err++;
        if (fq.size() > 0) pmem[pa] = fq.pop_front(); else viol++;
        c_pwr++;
      end
      if (mi[1]) begin
        if (pa != c_prd) addr_err++;
        sq.push_back(pmem[pa]);
        c_prd++;
      end
      if (bus.sum_valid) begin
        if (sq.size() > 0 && c_sv < 16) chk($sformatf("sum[%0d]", c_sv), sq.pop_front(), qd[c_sv] * job_ksum);
        else viol++;
        c_sv++;
      end
      if (bus.done) c_done++;
      if (bus.cfg_err) c_cfg++;
      if (fq.size() > fifo_max) fifo_max = fq.size();
      bus.fifo_valid = (fq.size() > 0);
    end
  end

  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int nq, input int nk, input int seed, input bit poke);
    job_ksum = 0;
    for (int r = 0; r < 16; r++) begin
      qd[r] = r * 7 + seed;
      kd[r] = 2 * r + seed + 1;
    end
    for (int j = 0; j < nk; j++) job_ksum += kd[j];
    bus.n_q = 5'(nq); bus.n_k = 5'(nk); bus.start = 1'b1;
    cyc1();
    bus.start = 1'b0;
    if (poke) begin
      bus.n_q = 5'd5; bus.n_k = 5'd5; bus.start = 1'b1;
      cyc1();
      bus.start = 1'b0;
    end
  endtask

  task automatic stream(input string tag, input int nq, input int nk, input int per);
    int idx = 0, cyc = 0;
    bit rdy;
    while (idx < nq + nk && cyc < 400) begin
      bus.in_valid = ((cyc % per) == 0);
      mem_in = (idx < nq) ? 16'(qd[idx]) : 16'(kd[idx - nq]);
      @(negedge clk) rdy = bus.in_ready;
      cyc1();
      if (rdy && bus.in_valid) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".rows_accepted"}, idx, nq + nk);
  endtask

  task automatic finish_job(input string tag, input int nq, input int nk);
    int cyc = 0;
    while (c_done == 0 && cyc < 3000) begin cyc1(); cyc++; end
    repeat (4) cyc1();
    chk({tag, ".done_once"}, c_done, 1);
    chk({tag, ".qwr_kwr"}, c_qwr * 256 + c_kwr, nq * 256 + nk);
    chk({tag, ".krd_load"}, c_krd * 256 + c_ld, nk * 256 + nk);
    chk({tag, ".qrd_exec"}, c_qrd * 256 + c_ex, nq * 256 + nq);
    chk({tag, ".pwr_prd"}, c_pwr * 256 + c_prd, nq * 256 + nq);
    chk({tag, ".sum_valid"}, c_sv, nq);
    chk({tag, ".addr_err"}, addr_err, 0);
    chk({tag, ".strobe_viol"}, viol, 0);
    chk({tag, ".idle_busy"}, int'({bus.busy, bus.in_ready}), 0);
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.n_q = '0; bus.n_k = '0; bus.in_valid = 1'b0; mem_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_state", int'({bus.inst, bus.busy, bus.in_ready, bus.sum_valid, bus.done, bus.cfg_err}), 0);
    cyc1();

    // nominal 8x8, in_valid held high
    start_job(8, 8, 3, 1'b0);
    stream("nom", 8, 8, 1);
    finish_job("nom", 8, 8);

    // reset for 3 cycles while executing, then a fresh job
    start_job(8, 8, 5, 1'b0);
    stream("rst", 8, 8, 1);
    cyc = 0;
    while (c_qrd < 3 && cyc < 200) begin cyc1(); cyc++; end
    chk("rst.reached_exec", int'(c_qrd >= 3), 1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst.inst_busy", int'({bus.inst, bus.busy, bus.in_ready}), 0);
    cyc1(); cyc1(); cyc1();
    reset = 1'b0;
    @(negedge clk);
    chk("rst.after_release", int'({bus.inst, bus.busy, bus.sum_valid, bus.done}), 0);
    cyc1();
    start_job(8, 8, 9, 1'b0);
    stream("rst2", 8, 8, 1);
    finish_job("rst2", 8, 8);

    // full depth 16x16
    start_job(16, 16, 1, 1'b0);
    stream("full", 16, 16, 1);
    finish_job("full", 16, 16);
    chk("full.ofifo_le8", int'(fifo_max <= 8), 1);

    // bubbles: one valid row every third cycle
    start_job(3, 2, 11, 1'b0);
    stream("bub", 3, 2, 3);
    finish_job("bub", 3, 2);
`ifdef ATTN_SEQ_PERF_EN
    chk("perf.cycles", int'(perf_cycles), busy_cyc);
    chk("perf.stall", int'(perf_stall), idle_cyc + 1);
`endif

    // zero count rejected
    start_job(4, 0, 2, 1'b0);
    repeat (4) cyc1();
    chk("cfg.err_pulse", c_cfg, 1);
    chk("cfg.busy_cycles", busy_cyc, 0);

    // start while busy is ignored; job keeps its 2x2 shape
    start_job(2, 2, 4, 1'b1);
    stream("poke", 2, 2, 1);
    finish_job("poke", 2, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
